operand_assembler: RTL

Upstream stage of the 64-bit ripple-carry adder in the UART adder datapath. Consumes the byte stream from the UART receiver and assembles two OP_WIDTH-bit operands, A then B, least-significant byte first. Presents them on a valid/ready handshake to the adder/result stage. Recovers from broken frames with an inter-byte timeout and flags bytes that arrive while a pair is pending.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/byte_deserializer.sv | 57 +++++
 rtl/operand_assembler.sv | 95 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the UART adder datapath.
package adder_pkg;

    localparam int unsigned OP_WIDTH_DEF = 64;

    typedef enum logic [1:0] {
        COLLECT_A = 2'd0,
        COLLECT_B = 2'd1,
        HOLD      = 2'd2
    } state_e;

    function automatic int unsigned nbytes(input int unsigned width);
        return width / 8;
    endfunction

    // Byte counter width; a one-byte operand still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_deserializer.sv
// Writes received bytes LSB-first into operand A or B and tracks the byte lane.
module byte_deserializer
    import adder_pkg::*;
#(
    parameter  int unsigned OP_WIDTH = OP_WIDTH_DEF,
    localparam int unsigned NBYTES   = nbytes(OP_WIDTH),
    localparam int unsigned CNT_W    = cnt_width(NBYTES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_i,
    input  logic                sel_b_i,
    input  logic                clr_i,
    input  logic [7:0]          data_i,
    output logic [OP_WIDTH-1:0] a_o,
    output logic [OP_WIDTH-1:0] b_o,
    output logic [CNT_W-1:0]    cnt_o
);

    logic [OP_WIDTH-1:0] a_q, a_d;
    logic [OP_WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (wr_i) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    if (sel_b_i) b_d[8*i +: 8] = data_i;
                    else         a_d[8*i +: 8] = data_i;
                end
            end
            cnt_d = (cnt_q == CNT_W'(NBYTES - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/operand_assembler.sv
// Assembles operands A and B from the UART byte stream and offers them on a
// valid/ready handshake, with inter-byte timeout and HOLD overrun reporting.
module operand_assembler
    import adder_pkg::*;
#(
    parameter int unsigned OP_WIDTH       = OP_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic [OP_WIDTH-1:0] a_o,
    output logic [OP_WIDTH-1:0] b_o,
    output logic                op_valid_o,
    input  logic                op_ready_i,
    output logic                overrun_o,
    output logic                timeout_o
);

    localparam int unsigned NBYTES = nbytes(OP_WIDTH);
    localparam int unsigned CNT_W  = cnt_width(NBYTES);
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               op_valid_q, overrun_q, timeout_q;

    logic accept, last, partial, expire, handshake, wr, sel_b, clr;

    byte_deserializer #(.OP_WIDTH(OP_WIDTH)) u_deser (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_i    (wr),
        .sel_b_i (sel_b),
        .clr_i   (clr),
        .data_i  (rx_data_i),
        .a_o     (a_o),
        .b_o     (b_o),
        .cnt_o   (cnt)
    );

    // State and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= COLLECT_A;
            tcnt_q     <= '0;
            op_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            op_valid_q <= (state_d == HOLD);
            overrun_q  <= rx_valid_i && (state_q == HOLD);
            timeout_q  <= expire;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT_A: if (accept && last) state_d = COLLECT_B;
            COLLECT_B: begin
                if (expire)              state_d = COLLECT_A;
                else if (accept && last) state_d = HOLD;
            end
            HOLD:      if (handshake) state_d = COLLECT_A;
            default:   state_d = COLLECT_A;
        endcase
    end

    // Datapath controls and idle counter.
    always_comb begin
        accept    = rx_valid_i && (state_q != HOLD);
        last      = (cnt == CNT_W'(NBYTES - 1));
        handshake = op_valid_q && op_ready_i;
        partial   = (state_q == COLLECT_B) || ((state_q == COLLECT_A) && (cnt != '0));
        expire    = (TIMEOUT_CYCLES != 0) && partial && !rx_valid_i
                    && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));
        wr        = accept;
        sel_b     = (state_q == COLLECT_B);
        clr       = expire || handshake;
        tcnt_d    = '0;
        if ((TIMEOUT_CYCLES != 0) && partial && !accept && !expire)
            tcnt_d = tcnt_q + TCNT_W'(1);
    end

    assign op_valid_o = op_valid_q;
    assign overrun_o  = overrun_q;
    assign timeout_o  = timeout_q;

endmodule
